// File: rtl/v_elem_sequencer.sv
// v_elem_sequencer: per-op element/partial-shift sequencer driving the lane validation tracker
module v_elem_sequencer #(
   parameter int MAX_VL_PER_LANE = 256,
   parameter int VLANE_NUM       = 8
) (
   input  logic                                          clk_i,
   input  logic                                          rst_i,
   input  logic [$clog2(VLANE_NUM*MAX_VL_PER_LANE)-1:0]  vl_i,
   input  logic                                          red_i,
   input  logic                                          req_valid_i,
   output logic                                          req_ready_o,
   input  logic                                          dst_ready_i,
   input  logic                                          red_ready_i,
   output logic                                          load_o,
   output logic                                          shift_en_o,
   output logic                                          shift_partial_o,
   output logic [$clog2(MAX_VL_PER_LANE):0]              beat_idx_o,
   output logic                                          busy_o,
   output logic                                          done_o
);
   localparam int VL_W = $clog2(VLANE_NUM*MAX_VL_PER_LANE);
   localparam int BW   = $clog2(MAX_VL_PER_LANE) + 1;
   localparam int LG   = $clog2(VLANE_NUM);
   localparam logic [2:0] IDLE = 3'd0, LOAD = 3'd1, ELEM = 3'd2, PART = 3'd3, DONE = 3'd4;
   logic [2:0]      state;
   logic [VL_W-1:0] vl_q;
   logic            red_q;
   logic [BW-1:0]   cnt;
   logic [BW-1:0]   nb;
   logic [LG-1:0]   pcnt;
   logic [VL_W:0]   vl_sum;
   // one extra bit so vl=max rounds up to MAX_VL_PER_LANE beats without overflow
   assign vl_sum          = {1'b0, vl_q} + (VL_W+1)'(VLANE_NUM - 1);
   assign nb              = vl_sum[VL_W:LG];
   assign req_ready_o     = state == IDLE;
   assign busy_o          = state != IDLE;
   assign load_o          = state == LOAD;
   assign shift_en_o      = state == ELEM && dst_ready_i;
   assign shift_partial_o = state == PART && red_ready_i;
   assign done_o          = state == DONE;
   assign beat_idx_o      = state == ELEM ? cnt : '0;
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state <= IDLE;
         vl_q  <= '0;
         red_q <= 1'b0;
         cnt   <= '0;
         pcnt  <= '0;
      end else begin
         case (state)
            IDLE: if (req_valid_i) begin
               state <= LOAD;
               vl_q  <= vl_i;
               red_q <= red_i;
               cnt   <= '0;
               pcnt  <= '0;
            end
            LOAD: state <= nb != '0 ? ELEM : red_q ? PART : DONE;
            ELEM: if (dst_ready_i) begin
               if (cnt == nb - BW'(1)) state <= red_q ? PART : DONE;
               else cnt <= cnt + BW'(1);
            end
            PART: if (red_ready_i) begin
               if (pcnt == LG'(VLANE_NUM - 2)) state <= DONE;
               else pcnt <= pcnt + LG'(1);
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_v_elem_sequencer.sv
// tb_v_elem_sequencer: directed checks of v_elem_sequencer (VLANE_NUM=8, MAX_VL_PER_LANE=256)
module tb_v_elem_sequencer;
   logic        clk_i = 1'b0;
   logic        rst_i = 1'b0;
   logic [10:0] vl_i = '0;
   logic        red_i = 1'b0;
   logic        req_valid_i = 1'b0;
   logic        req_ready_o;
   logic        dst_ready_i = 1'b0;
   logic        red_ready_i = 1'b0;
   logic        load_o;
   logic        shift_en_o;
   logic        shift_partial_o;
   logic [8:0]  beat_idx_o;
   logic        busy_o;
   logic        done_o;

   int n_cmp = 0;
   int n_err = 0;
   int n_load, n_shift, n_part, done_c, load_c, first_shift, first_part, last_part;
   int last_idx, idx_err, excl_err, stall_err, done_seen;

   v_elem_sequencer #(.MAX_VL_PER_LANE(256), .VLANE_NUM(8)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .vl_i(vl_i), .red_i(red_i),
      .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
      .dst_ready_i(dst_ready_i), .red_ready_i(red_ready_i),
      .load_o(load_o), .shift_en_o(shift_en_o), .shift_partial_o(shift_partial_o),
      .beat_idx_o(beat_idx_o), .busy_o(busy_o), .done_o(done_o)
   );

   always #5 clk_i = ~clk_i;

   // accept one op, then tally pulses until done_o; dst/red low when c%k==k-1 (k=0: always high)
   task automatic run(input logic [10:0] vl, input logic r, input int dst_k, input int red_k);
      int exp_idx;
      int nb;
      nb = (int'(vl) + 7) >> 3;
      n_load = 0; n_shift = 0; n_part = 0; done_c = -1; load_c = -1; first_shift = -1;
      first_part = -1; last_part = -1; last_idx = -1; idx_err = 0; excl_err = 0;
      stall_err = 0; done_seen = 0; exp_idx = 0;
      vl_i = vl; red_i = r; req_valid_i = 1'b1;
      #1;
      @(posedge clk_i); #1;
      req_valid_i = 1'b0; vl_i = ~vl; red_i = ~r;
      for (int c = 0; c < 3000; c++) begin
         dst_ready_i = dst_k == 0 ? 1'b1 : (c % dst_k) != dst_k - 1;
         red_ready_i = red_k == 0 ? 1'b1 : (c % red_k) != red_k - 1;
         #1;
         if (int'(load_o) + int'(shift_en_o) + int'(shift_partial_o) > 1) excl_err++;
         if (load_o) begin n_load++; load_c = c; end
         if (shift_en_o) begin
            if (int'(beat_idx_o) != exp_idx) idx_err++;
            if (first_shift < 0) first_shift = c;
            last_idx = int'(beat_idx_o);
            exp_idx++;
         end else if (busy_o && n_shift > 0 && exp_idx < nb) begin
            if (dst_ready_i || int'(beat_idx_o) != exp_idx) stall_err++;
         end
         n_shift = exp_idx;
         if (shift_partial_o) begin
            n_part++;
            if (first_part < 0) first_part = c;
            last_part = c;
         end
         if (done_o) begin done_c = c; done_seen = 1; break; end
         @(posedge clk_i); #1;
      end
      @(posedge clk_i); #1;
   endtask

   task automatic test_reset;
      #1;
      n_cmp++; if (req_ready_o !== 1'b1) begin n_err++; $display("FAIL reset_req_ready got %b exp 1", req_ready_o); end
      n_cmp++; if ({load_o, shift_en_o, shift_partial_o, busy_o, done_o} !== 5'b0) begin n_err++; $display("FAIL reset_outs got %b exp 00000", {load_o, shift_en_o, shift_partial_o, busy_o, done_o}); end
      n_cmp++; if (beat_idx_o !== 9'd0) begin n_err++; $display("FAIL reset_beat_idx got %0d exp 0", beat_idx_o); end
      @(negedge clk_i); rst_i = 1'b1;
      @(posedge clk_i); #1;
   endtask

   task automatic test_plain;
      run(11'd17, 1'b0, 0, 0);
      n_cmp++; if (n_load != 1 || load_c != 0) begin n_err++; $display("FAIL plain_load got n=%0d c=%0d exp n=1 c=0", n_load, load_c); end
      n_cmp++; if (n_shift != 3 || first_shift != 1) begin n_err++; $display("FAIL plain_shifts got n=%0d first=%0d exp n=3 first=1", n_shift, first_shift); end
      n_cmp++; if (idx_err != 0 || last_idx != 2) begin n_err++; $display("FAIL plain_idx got err=%0d last=%0d exp err=0 last=2", idx_err, last_idx); end
      n_cmp++; if (done_c != 4 || n_part != 0) begin n_err++; $display("FAIL plain_done got c=%0d part=%0d exp c=4 part=0", done_c, n_part); end
   endtask

   task automatic test_reduction;
      run(11'd8, 1'b1, 0, 2);
      n_cmp++; if (n_shift != 1) begin n_err++; $display("FAIL red_beats got %0d exp 1", n_shift); end
      n_cmp++; if (n_part != 7) begin n_err++; $display("FAIL red_parts got %0d exp 7", n_part); end
      n_cmp++; if (last_part - first_part != 12 || first_part != 2) begin n_err++; $display("FAIL red_span got first=%0d last=%0d exp first=2 last=14", first_part, last_part); end
      n_cmp++; if (done_c != 15 || excl_err != 0) begin n_err++; $display("FAIL red_done got c=%0d excl=%0d exp c=15 excl=0", done_c, excl_err); end
   endtask

   task automatic test_zero_vl;
      run(11'd0, 1'b0, 0, 0);
      n_cmp++; if (n_load != 1 || n_shift != 0 || n_part != 0 || done_c != 1) begin n_err++; $display("FAIL vl0_plain got load=%0d sh=%0d pt=%0d done=%0d exp 1 0 0 1", n_load, n_shift, n_part, done_c); end
      run(11'd0, 1'b1, 0, 0);
      n_cmp++; if (n_shift != 0 || n_part != 7 || done_c != 8) begin n_err++; $display("FAIL vl0_red got sh=%0d pt=%0d done=%0d exp 0 7 8", n_shift, n_part, done_c); end
   endtask

   task automatic test_max_vl;
      run(11'd2047, 1'b0, 3, 0);
      n_cmp++; if (n_shift != 256) begin n_err++; $display("FAIL max_beats got %0d exp 256", n_shift); end
      n_cmp++; if (last_idx != 255 || idx_err != 0) begin n_err++; $display("FAIL max_idx got last=%0d err=%0d exp last=255 err=0", last_idx, idx_err); end
      n_cmp++; if (stall_err != 0 || excl_err != 0) begin n_err++; $display("FAIL max_stall got stall=%0d excl=%0d exp 0 0", stall_err, excl_err); end
      n_cmp++; if (done_seen != 1 || n_part != 0) begin n_err++; $display("FAIL max_done got seen=%0d part=%0d exp 1 0", done_seen, n_part); end
   endtask

   task automatic test_back_to_back;
      int rdy_err = 0;
      int sh = 0;
      int seen = 0;
      dst_ready_i = 1'b1; red_ready_i = 1'b1;
      vl_i = 11'd16; red_i = 1'b0; req_valid_i = 1'b1;
      @(posedge clk_i); #1;
      vl_i = 11'd5;
      for (int c = 0; c < 20 && !seen; c++) begin
         #1;
         if (req_ready_o || !busy_o) rdy_err++;
         if (done_o) seen = 1;
         @(posedge clk_i); #1;
      end
      n_cmp++; if (rdy_err != 0 || seen != 1) begin n_err++; $display("FAIL b2b_hold got err=%0d done=%0d exp 0 1", rdy_err, seen); end
      n_cmp++; if (req_ready_o !== 1'b1 || busy_o !== 1'b0) begin n_err++; $display("FAIL b2b_idle got rdy=%b busy=%b exp 1 0", req_ready_o, busy_o); end
      @(posedge clk_i); #1;
      req_valid_i = 1'b0; vl_i = 11'd100;
      n_cmp++; if (load_o !== 1'b1) begin n_err++; $display("FAIL b2b_load got %b exp 1", load_o); end
      seen = 0;
      for (int c = 0; c < 20 && !seen; c++) begin
         #1;
         if (shift_en_o) sh++;
         if (done_o) seen = 1;
         @(posedge clk_i); #1;
      end
      n_cmp++; if (sh != 1 || seen != 1) begin n_err++; $display("FAIL b2b_second_vl got beats=%0d done=%0d exp 1 1", sh, seen); end
   endtask

   task automatic test_reset_mid;
      dst_ready_i = 1'b1;
      vl_i = 11'd80; red_i = 1'b1; req_valid_i = 1'b1;
      @(posedge clk_i); #1;
      req_valid_i = 1'b0;
      repeat (6) begin @(posedge clk_i); #1; end
      #1;
      n_cmp++; if (beat_idx_o !== 9'd5 || shift_en_o !== 1'b1) begin n_err++; $display("FAIL mid_pre_idx got %0d en=%b exp 5 1", beat_idx_o, shift_en_o); end
      #1; rst_i = 1'b0; #1;
      n_cmp++; if ({load_o, shift_en_o, shift_partial_o, busy_o, done_o} !== 5'b0 || beat_idx_o !== 9'd0) begin n_err++; $display("FAIL mid_reset_outs got %b idx=%0d exp 00000 0", {load_o, shift_en_o, shift_partial_o, busy_o, done_o}, beat_idx_o); end
      n_cmp++; if (req_ready_o !== 1'b1) begin n_err++; $display("FAIL mid_reset_ready got %b exp 1", req_ready_o); end
      @(negedge clk_i); rst_i = 1'b1;
      @(posedge clk_i); #1;
      run(11'd24, 1'b0, 0, 0);
      n_cmp++; if (n_shift != 3 || idx_err != 0 || last_idx != 2 || done_c != 4) begin n_err++; $display("FAIL mid_restart got sh=%0d err=%0d last=%0d done=%0d exp 3 0 2 4", n_shift, idx_err, last_idx, done_c); end
   endtask

   initial begin
      test_reset;
      test_plain;
      test_reduction;
      test_zero_vl;
      test_max_vl;
      test_back_to_back;
      test_reset_mid;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
